// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer:
// FSM states, CSR addresses, mcause codes and CSR bit positions.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    MRET = 2'd2
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL    = 32'd11;
  localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSRs (mstatus MIE/MPIE, mie MEIE, mtvec, mepc, mcause, mip) with a
// hardware trap/mret update port, a software write port and a read mux.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hw_trap_i,
  input  logic        hw_mret_i,
  input  logic [31:0] hw_cause_i,
  input  logic [31:0] hw_pc_i,
  input  logic        sw_we_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        irq_ext_i,
  output logic [31:0] rdata_o,
  output logic        mstatus_mie_o,
  output logic        mie_meie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  // Hardware updates and software writes never coincide, so trap/mret win.
  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (hw_trap_i) begin
      mepc_d   = hw_pc_i & ALIGN_MASK;
      mcause_d = hw_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (hw_mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (sw_we_i) begin
      case (addr_i)
        CSR_MSTATUS: begin
          mie_d  = wdata_i[MSTATUS_MIE];
          mpie_d = wdata_i[MSTATUS_MPIE];
        end
        CSR_MIE:    meie_d   = wdata_i[MIE_MEIE];
        CSR_MTVEC:  mtvec_d  = wdata_i & ALIGN_MASK;
        CSR_MEPC:   mepc_d   = wdata_i & ALIGN_MASK;
        CSR_MCAUSE: mcause_d = wdata_i;
        default:    ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC & ALIGN_MASK;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      meie_q   <= meie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CSR_MSTATUS: begin
        rdata_o[MSTATUS_MIE]  = mie_q;
        rdata_o[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MIE:    rdata_o[MIE_MEIE] = meie_q;
      CSR_MTVEC:  rdata_o = mtvec_q;
      CSR_MEPC:   rdata_o = mepc_q;
      CSR_MCAUSE: rdata_o = mcause_q;
      CSR_MIP:    rdata_o[MIP_MEIP] = irq_ext_i;
      default:    rdata_o = '0;
    endcase
  end

  assign mstatus_mie_o = mie_q;
  assign mie_meie_o    = meie_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks one event per EX boundary, squashes the
// EX instruction, updates the trap CSRs and redirects fetch for one cycle.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_busy,
  input  logic [31:0] ex_pc,
  input  logic        ex_ecall,
  input  logic        ex_ebreak,
  input  logic        ex_illegal,
  input  logic        ex_mret,
  input  logic        irq_ext,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        trap_kill_ex,
  output logic        trap_pc_valid,
  output logic [31:0] trap_pc,
  output logic        trap_flush,
  output logic        trap_busy
);

  state_e      state_q, state_d;
  logic        bnd, irq_take, trap_take, mret_take, sw_we;
  logic        mstatus_mie, mie_meie;
  logic [31:0] cause, mtvec, mepc;

  assign bnd       = ex_valid & ~ex_busy & (state_q == IDLE);
  assign irq_take  = irq_ext & mstatus_mie & mie_meie;
  assign trap_take = bnd & (irq_take | ex_illegal | ex_ebreak | ex_ecall);
  assign mret_take = bnd & ex_mret & ~trap_take;

  assign trap_kill_ex = trap_take | mret_take;
  assign sw_we        = csr_we & ex_valid & ~trap_kill_ex & (state_q == IDLE);

  always_comb begin
    cause = CAUSE_ECALL;
    if (irq_take)        cause = CAUSE_MEXT_IRQ;
    else if (ex_illegal) cause = CAUSE_ILLEGAL;
    else if (ex_ebreak)  cause = CAUSE_EBREAK;
  end

  trap_csr_file #(.RESET_MTVEC(RESET_MTVEC)) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .hw_trap_i     (trap_take),
    .hw_mret_i     (mret_take),
    .hw_cause_i    (cause),
    .hw_pc_i       (ex_pc),
    .sw_we_i       (sw_we),
    .addr_i        (csr_addr),
    .wdata_i       (csr_wdata),
    .irq_ext_i     (irq_ext),
    .rdata_o       (csr_rdata),
    .mstatus_mie_o (mstatus_mie),
    .mie_meie_o    (mie_meie),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (state_q == IDLE) begin
      if (trap_take)      state_d = TRAP;
      else if (mret_take) state_d = MRET;
    end
  end

  // Redirect outputs decode the state register only, so async reset clears them at once.
  always_comb begin
    trap_pc_valid = 1'b0;
    trap_pc       = '0;
    trap_flush    = 1'b0;
    trap_busy     = 1'b0;
    case (state_q)
      TRAP: begin
        trap_pc_valid = 1'b1;
        trap_pc       = mtvec;
        trap_flush    = 1'b1;
        trap_busy     = 1'b1;
      end
      MRET: begin
        trap_pc_valid = 1'b1;
        trap_pc       = mepc;
        trap_flush    = 1'b1;
        trap_busy     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
